// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC-driven instruction prefetcher with a small valid/ready buffer
`timescale 1ns/1ps
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       iin,
    output logic              iin_valid,
    input  logic              iin_ready,
    output logic [ADDR_W-1:0] iin_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);

    localparam int             PW       = (DEPTH > 2) ? 2 : 1;
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
    localparam logic [2:0]     DEPTH_C  = 3'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_count;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_infl_addr;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [15:0]       r_buf_data [DEPTH];
    logic [ADDR_W-1:0] r_buf_pc   [DEPTH];

    logic          w_issue;
    logic          w_write;
    logic          w_pop;
    logic [PW-1:0] w_head_nxt;
    logic [PW-1:0] w_tail_nxt;

    // Credit counts the in-flight read but never a same-cycle pop, so a return always finds a free slot.
    assign w_issue    = resetn && !redirect && ((r_count + {2'b00, r_inflight}) < DEPTH_C);
    assign w_write    = r_inflight && !redirect;
    assign w_pop      = (r_count != 3'd0) && iin_ready && !redirect;
    assign w_head_nxt = (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;

    assign mem_rd    = w_issue;
    assign mem_addr  = r_pc;
    assign iin_valid = (r_count != 3'd0);
    assign iin       = iin_valid ? r_buf_data[r_head] : 16'h0000;
    assign iin_pc    = iin_valid ? r_buf_pc[r_head] : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc        <= '0;
            r_count     <= 3'd0;
            r_inflight  <= 1'b0;
            r_infl_addr <= '0;
            r_head      <= '0;
            r_tail      <= '0;
        end else if (redirect) begin
            r_pc       <= redirect_addr;
            r_count    <= 3'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc        <= r_pc + ADDR_W'(1);
                r_infl_addr <= r_pc;
            end
            if (w_write) begin
                r_tail <= w_tail_nxt;
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_buf_data[r_tail] <= mem_rdata;
            r_buf_pc[r_tail]   <= r_infl_addr;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        w_write |-> (r_count < DEPTH_C));

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] iin;
    logic        iin_valid;
    logic        iin_ready;
    logic [7:0]  iin_pc;
    logic        redirect;
    logic [7:0]  redirect_addr;

    logic [15:0] mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_addr;
    int          accepted;

    instr_fetch #(.ADDR_W(8), .DEPTH(2)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .iin           (iin),
        .iin_valid     (iin_valid),
        .iin_ready     (iin_ready),
        .iin_pc        (iin_pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    always #5 clock = ~clock;

    // Synchronous memory: data for a read appears one cycle later; junk otherwise.
    always @(posedge clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 16'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive inputs for the next edge, score the pop the reference expects, advance.
    task automatic cycle(input logic rdy, input logic redir, input logic [7:0] raddr);
        iin_ready     = rdy;
        redirect      = redir;
        redirect_addr = raddr;
        #1;
        if (!iin_valid) begin
            check("empty_iin", iin, 16'h0000);
            check("empty_pc", iin_pc, 8'h00);
        end
        if (redir) begin
            check("redir_mem_rd", mem_rd, 1'b0);
        end else if (rdy && iin_valid) begin
            check("pop_data", iin, mem[exp_addr]);
            check("pop_pc", iin_pc, exp_addr);
            exp_addr++;
            accepted++;
        end
        @(posedge clock);
        @(negedge clock);
        redirect = 1'b0;
        if (redir) begin
            exp_addr = raddr;
            check("redir_flush", iin_valid, 1'b0);
        end
    endtask

    task automatic stream_until(input int n, input int budget, input string tag);
        int c = 0;
        while (accepted < n && c < budget) begin
            cycle(1'b1, 1'b0, 8'h00);
            c++;
        end
        check(tag, accepted >= n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'hA000 + 16'(k);
        resetn        = 1'b0;
        iin_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        exp_addr      = 8'h00;
        accepted      = 0;

        repeat (2) @(negedge clock);
        #1;
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_valid", iin_valid, 1'b0);
        check("rst_iin", iin, 16'h0000);
        check("rst_pc", iin_pc, 8'h00);
        resetn = 1'b1;
        #1;
        check("fill0_rd", mem_rd, 1'b1);
        check("fill0_addr", mem_addr, 8'h00);

        cycle(1'b0, 1'b0, 8'h00);
        check("fill1_rd", mem_rd, 1'b1);
        check("fill1_addr", mem_addr, 8'h01);
        check("fill1_valid", iin_valid, 1'b0);
        cycle(1'b0, 1'b0, 8'h00);
        check("fill2_rd", mem_rd, 1'b0);
        check("fill2_valid", iin_valid, 1'b1);
        check("fill2_iin", iin, 16'hA000);
        check("fill2_pc", iin_pc, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("fill3_rd", mem_rd, 1'b0);
        check("fill3_iin", iin, 16'hA000);

        accepted = 0;
        repeat (20) cycle(1'b1, 1'b0, 8'h00);
        check("stream_rate", accepted >= 10, 1'b1);
        check("stream_order", exp_addr, 8'(accepted));

        cycle(1'b0, 1'b1, 8'hFE);
        accepted = 0;
        stream_until(4, 30, "wrap_budget");
        check("wrap_end", exp_addr, 8'h02);

        cycle(1'b0, 1'b1, 8'h10);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("full_valid", iin_valid, 1'b1);
        check("full_rd", mem_rd, 1'b0);
        check("full_iin", iin, 16'hA010);
        cycle(1'b0, 1'b1, 8'h40);
        cycle(1'b0, 1'b0, 8'h00);
        check("post_redir_valid", iin_valid, 1'b0);
        accepted = 0;
        stream_until(1, 10, "redir40_budget");
        check("redir40_next", exp_addr, 8'h41);

        for (int k = 0; k < 5 && !iin_valid; k++) cycle(1'b0, 1'b0, 8'h00);
        check("popredir_pre", iin_valid, 1'b1);
        cycle(1'b1, 1'b1, 8'h80);
        accepted = 0;
        stream_until(2, 12, "popredir_budget");
        check("popredir_next", exp_addr, 8'h82);

        repeat (5) cycle(1'b1, 1'b0, 8'h00);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", iin_valid, 1'b0);
        check("mid_rst_iin", iin, 16'h0000);
        check("mid_rst_rd", mem_rd, 1'b0);
        @(negedge clock);
        resetn   = 1'b1;
        exp_addr = 8'h00;
        accepted = 0;
        stream_until(3, 15, "restart_budget");
        check("restart_next", exp_addr, 8'h03);

        accepted = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, 8'($urandom));
        end
        check("random_progress", accepted > 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
